// File: rtl/led_scan_sequencer_if.sv
// Bundle of host-control and panel/FIFO-side signals of the LED scan sequencer.
// The master modport is the sequencer itself; the slave modport is the view
// seen by the host and the panel/FIFO/receiver logic around it.
interface led_scan_sequencer_if #(
    parameter int ROW_BITS = 4
);
    logic                enable;
    logic                start;
    logic                rrst_n;
    logic                re_n;
    logic                rx_nrst;
    logic [7:0]          pwm_value;
    logic [ROW_BITS-1:0] row_addr;
    logic                lat;
    logic                oe_n;
    logic                busy;
    logic                frame_done;

    modport master (
        input  enable, start,
        output rrst_n, re_n, rx_nrst, pwm_value, row_addr, lat, oe_n, busy, frame_done
    );

    modport slave (
        output enable, start,
        input  rrst_n, re_n, rx_nrst, pwm_value, row_addr, lat, oe_n, busy, frame_done
    );
endinterface

// File: rtl/led_scan_sequencer.sv
// Scan scheduler for a HUB-style LED panel: re-reads the AL422 frame once per
// PWM pass, shifting every row, latching it and blanking between lines.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start & enable, panel dark
// S_RRST  | 2 cycles of AL422 read-pointer reset at the top of a pass
// S_SHIFT | COLS*2 byte reads from the AL422 into the pixel receiver
// S_FLUSH | 1 cycle letting the receiver complete the final byte pair
// S_BLANK | BLANK_CYCLES dark cycles; latch on the first, advance on the last
module led_scan_sequencer #(
    parameter int COLS         = 64,
    parameter int ROWS         = 16,
    parameter int ROW_BITS     = 4,
    parameter int PWM_BITS     = 5,
    parameter int BLANK_CYCLES = 4
) (
    input logic                  in_clk,
    input logic                  in_nrst,
    led_scan_sequencer_if.master bus
);
    localparam int BYTES  = COLS * 2;
    localparam int BYTE_W = $clog2(BYTES);
    localparam int TMR_W  = $clog2(BLANK_CYCLES);

    localparam logic [BYTE_W-1:0]   BYTE_LAST = BYTE_W'(BYTES - 1);
    localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(ROWS - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = '1;
    localparam logic [TMR_W-1:0]    RRST_LOAD  = TMR_W'(1);
    localparam logic [TMR_W-1:0]    BLANK_LOAD = TMR_W'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RRST,
        S_SHIFT,
        S_FLUSH,
        S_BLANK
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [ROW_BITS-1:0] row_cnt_q, row_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

    logic                rrst_n_q, rrst_n_d;
    logic                re_n_q, re_n_d;
    logic                rx_nrst_q, rx_nrst_d;
    logic [7:0]          pwm_value_q, pwm_value_d;
    logic [ROW_BITS-1:0] row_addr_q, row_addr_d;
    logic                lat_q, lat_d;
    logic                oe_n_q, oe_n_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;

    // Next state and counters; outputs are derived from the next state so the
    // registered values line up with the cycle the FSM is in.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tmr_d        = tmr_q;
        row_cnt_d    = row_cnt_q;
        pwm_cnt_d    = pwm_cnt_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && bus.enable) begin
                    state_d   = S_RRST;
                    tmr_d     = RRST_LOAD;
                    row_cnt_d = '0;
                    pwm_cnt_d = '0;
                end
            end
            S_RRST: begin
                if (tmr_q == '0) begin
                    state_d    = S_SHIFT;
                    byte_cnt_d = '0;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            S_SHIFT: begin
                if (byte_cnt_q == BYTE_LAST) begin
                    state_d = S_FLUSH;
                end else begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
            end
            S_FLUSH: begin
                state_d = S_BLANK;
                tmr_d   = BLANK_LOAD;
            end
            S_BLANK: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - 1'b1;
                end else if (row_cnt_q != ROW_LAST) begin
                    row_cnt_d  = row_cnt_q + 1'b1;
                    byte_cnt_d = '0;
                    state_d    = S_SHIFT;
                end else begin
                    row_cnt_d = '0;
                    tmr_d     = RRST_LOAD;
                    if (pwm_cnt_q != PWM_LAST) begin
                        pwm_cnt_d = pwm_cnt_q + 1'b1;
                        state_d   = S_RRST;
                    end else begin
                        // enable is only looked at here, so frames are never torn
                        pwm_cnt_d    = '0;
                        frame_done_d = 1'b1;
                        state_d      = bus.enable ? S_RRST : S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d    = (state_d != S_IDLE);
        rrst_n_d  = (state_d != S_RRST);
        re_n_d    = (state_d != S_SHIFT);
        // AL422 data trails re_n by one cycle, so the receiver wakes on byte 1
        rx_nrst_d = ((state_d == S_SHIFT) && (byte_cnt_d != '0)) || (state_d == S_FLUSH);
        lat_d     = (state_d == S_BLANK) && (state_q == S_FLUSH);
        row_addr_d = lat_d ? row_cnt_q : row_addr_q;
        // First line of every pass stays dark: the panel latch does not yet hold
        // a row of this pass.
        oe_n_d    = !(((state_d == S_SHIFT) || (state_d == S_FLUSH)) && (row_cnt_d != '0));
        pwm_value_d = ((state_d == S_RRST) && (state_q != S_RRST)) ? 8'(pwm_cnt_d) : pwm_value_q;
    end

    // State, counters and registered outputs with synchronous active-low reset.
    always_ff @(posedge in_clk) begin
        if (!in_nrst) begin
            state_q      <= S_IDLE;
            byte_cnt_q   <= '0;
            tmr_q        <= '0;
            row_cnt_q    <= '0;
            pwm_cnt_q    <= '0;
            rrst_n_q     <= 1'b1;
            re_n_q       <= 1'b1;
            rx_nrst_q    <= 1'b0;
            pwm_value_q  <= '0;
            row_addr_q   <= '0;
            lat_q        <= 1'b0;
            oe_n_q       <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tmr_q        <= tmr_d;
            row_cnt_q    <= row_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            rrst_n_q     <= rrst_n_d;
            re_n_q       <= re_n_d;
            rx_nrst_q    <= rx_nrst_d;
            pwm_value_q  <= pwm_value_d;
            row_addr_q   <= row_addr_d;
            lat_q        <= lat_d;
            oe_n_q       <= oe_n_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.rrst_n     = rrst_n_q;
    assign bus.re_n       = re_n_q;
    assign bus.rx_nrst    = rx_nrst_q;
    assign bus.pwm_value  = pwm_value_q;
    assign bus.row_addr   = row_addr_q;
    assign bus.lat        = lat_q;
    assign bus.oe_n       = oe_n_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_led_scan_sequencer.sv
// Bench for led_scan_sequencer in the small configuration. A position-in-frame
// model predicts every output each cycle; directed sections pin frame timing
// with hand-computed literals.
module tb_led_scan_sequencer;
    localparam int COLS     = 4;
    localparam int ROWS     = 2;
    localparam int ROW_BITS = 1;
    localparam int PWM_BITS = 2;
    localparam int BLANK    = 4;
    localparam int LINE     = COLS * 2 + 1 + BLANK;
    localparam int PASS     = 2 + ROWS * LINE;
    localparam int NPASS    = 1 << PWM_BITS;
    localparam int FRAME    = NPASS * PASS;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    led_scan_sequencer_if #(.ROW_BITS(ROW_BITS)) bus ();

    led_scan_sequencer #(
        .COLS(COLS), .ROWS(ROWS), .ROW_BITS(ROW_BITS),
        .PWM_BITS(PWM_BITS), .BLANK_CYCLES(BLANK)
    ) dut (
        .in_clk (clk),
        .in_nrst(nrst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endfunction

    // Model: where in the frame are we (pass index, cycle within pass)
    bit         m_run;
    int         m_pos;
    int         m_pass;
    logic [7:0] m_pwm;
    int         m_row;
    bit         m_fd;

    always @(posedge clk) begin
        if (!nrst) begin
            m_run = 0; m_pos = 0; m_pass = 0; m_pwm = 8'd0; m_row = 0; m_fd = 0;
        end else begin
            m_fd = 0;
            if (!m_run) begin
                if (bus.start && bus.enable) begin
                    m_run = 1; m_pos = 0; m_pass = 0; m_pwm = 8'd0;
                end
            end else begin
                m_pos++;
                if (m_pos == PASS) begin
                    m_pos = 0;
                    m_pass++;
                    if (m_pass == NPASS) begin
                        m_pass = 0;
                        m_fd   = 1;
                        if (!bus.enable) m_run = 0;
                    end
                    if (m_run) m_pwm = 8'(m_pass);
                end
                if (m_run && m_pos >= 2 && ((m_pos - 2) % LINE) == 2 * COLS + 1)
                    m_row = (m_pos - 2) / LINE;
            end
        end
    end

    // Compare every output against the model on every cycle
    always @(negedge clk) begin : compare
        int l, o;
        bit rr, sh, fl, bl;
        if (chk_en) begin
            rr = 0; sh = 0; fl = 0; bl = 0; l = 0; o = 0;
            if (m_run) begin
                if (m_pos < 2) rr = 1;
                else begin
                    l  = (m_pos - 2) / LINE;
                    o  = (m_pos - 2) % LINE;
                    sh = (o < 2 * COLS);
                    fl = (o == 2 * COLS);
                    bl = (o > 2 * COLS);
                end
            end
            chk("rrst_n",     16'(bus.rrst_n),     16'(!rr));
            chk("re_n",       16'(bus.re_n),       16'(!sh));
            chk("rx_nrst",    16'(bus.rx_nrst),    16'((sh && o >= 1) || fl));
            chk("lat",        16'(bus.lat),        16'(bl && o == 2 * COLS + 1));
            chk("oe_n",       16'(bus.oe_n),       16'(!((sh || fl) && l != 0)));
            chk("busy",       16'(bus.busy),       16'(m_run));
            chk("pwm_value",  16'(bus.pwm_value),  16'(m_pwm));
            chk("row_addr",   16'(bus.row_addr),   16'(m_row));
            chk("frame_done", 16'(bus.frame_done), 16'(m_fd));
        end
    end

    initial begin
        int rr_lo, re_lo, lat_n, lat1, lat2, fd_at, oe_bad, n;
        bus.enable = 1'b0;
        bus.start  = 1'b0;
        nrst       = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1;

        // Reset release, idle with start low
        nrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.enable = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("idle_busy", 16'(bus.busy), 16'd0);
        chk("idle_oe_n", 16'(bus.oe_n), 16'd1);

        // One full frame from a start pulse, with a stray start during SHIFT
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        rr_lo = 0; re_lo = 0; lat_n = 0; lat1 = -1; lat2 = -1; fd_at = -1; oe_bad = 0;
        for (int k = 0; k <= FRAME; k++) begin
            if (k < FRAME) begin
                if (!bus.rrst_n) rr_lo++;
                if (!bus.re_n) re_lo++;
                if (bus.lat) begin
                    if (lat_n == 0) lat1 = k;
                    else if (lat_n == 1) lat2 = k;
                    lat_n++;
                end
                if ((k % PASS) >= 2 && (k % PASS) < 2 + LINE && !bus.oe_n) oe_bad++;
                if ((k % PASS) == 0) chk("pass_pwm", 16'(bus.pwm_value), 16'(k / PASS));
            end
            if (bus.frame_done && fd_at < 0) fd_at = k;
            bus.start = (k == 5);
            if (k < FRAME) @(negedge clk);
        end
        bus.start = 1'b0;
        chk("rrst_low_cycles", 16'(rr_lo), 16'd8);
        chk("re_low_cycles",   16'(re_lo), 16'd64);
        chk("lat_count",       16'(lat_n), 16'd8);
        chk("lat_first",       16'(lat1),  16'd11);
        chk("lat_second",      16'(lat2),  16'd24);
        chk("frame_done_at",   16'(fd_at), 16'd112);
        chk("oe_first_line",   16'(oe_bad), 16'd0);

        // Free-run into a second frame, drop enable during pass 1
        repeat (PASS + 5) @(negedge clk);
        bus.enable = 1'b0;
        n = PASS + 5;
        while (bus.busy && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk("drain_len",     16'(n), 16'(FRAME));
        chk("drain_oe_n",    16'(bus.oe_n), 16'd1);
        chk("drain_fd",      16'(bus.frame_done), 16'd1);
        repeat (10) @(negedge clk);

        // Reset during SHIFT byte 5 of the first line
        bus.enable = 1'b1;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_re_n", 16'(bus.re_n), 16'd0);
        nrst = 1'b0;
        @(negedge clk);
        chk("rst_re_n",    16'(bus.re_n), 16'd1);
        chk("rst_oe_n",    16'(bus.oe_n), 16'd1);
        chk("rst_busy",    16'(bus.busy), 16'd0);
        chk("rst_rx_nrst", 16'(bus.rx_nrst), 16'd0);
        nrst       = 1'b1;
        bus.enable = 1'b0;
        repeat (5) @(negedge clk);

        // Randomized control traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            bus.enable = ($urandom_range(0, 9) != 0);
            bus.start  = ($urandom_range(0, 15) == 0);
            nrst       = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        bus.start  = 1'b0;
        bus.enable = 1'b0;
        nrst       = 1'b1;
        repeat (2 * FRAME) @(negedge clk);
        chk("final_busy", 16'(bus.busy), 16'd0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
